// File: rtl/eaglesong_permutation_iter.sv
// Iterative Eaglesong permutation over a 16 x 32-bit state.
// Evaluates ROUNDS_PER_CYCLE chained rounds per clock; round constants arrive from an external ROM.
module eaglesong_permutation_iter #(
    parameter int NUM_ROUNDS       = 43,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [15:0][31:0]                 state_input,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [15:0][31:0]                 state_output,
    output logic [5:0]                        rc_base_round,
    input  logic [ROUNDS_PER_CYCLE*512-1:0]   rc_consts
);

    localparam logic [255:0] BIT_MATRIX =
        256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf;
    localparam int ROT_A [16] = '{2, 13, 4, 3, 27, 3, 17, 3, 18, 12, 4, 4, 12, 7, 7, 1};
    localparam int ROT_B [16] = '{4, 22, 19, 14, 31, 8, 26, 12, 22, 18, 7, 31, 27, 17, 8, 13};
    // Seven bits so round + ROUNDS_PER_CYCLE never wraps even at the largest settings.
    localparam logic [6:0] NUM_ROUNDS_W = 7'(NUM_ROUNDS);
    localparam logic [6:0] RPC_W        = 7'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                    state_reg, state_next;
    logic [15:0][31:0]       work_reg, work_next;
    logic [15:0][31:0]       out_reg, out_next;
    logic [6:0]              round_reg, round_next;
    logic                    out_valid_reg, out_valid_next;
    logic [6:0]              round_sum;
    logic [15:0][31:0]       round_out;
    logic [ROUNDS_PER_CYCLE-1:0] sub_active;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [15:0][31:0] es_round(input logic [15:0][31:0] s,
                                                   input logic [511:0]      rc);
        logic [15:0][31:0] bm;
        logic [15:0][31:0] t;
        logic [31:0]       lo;
        logic [31:0]       hi;
        for (int j = 0; j < 16; j++) begin
            bm[j] = '0;
            for (int i = 0; i < 16; i++) begin
                if (BIT_MATRIX[16*i+j]) begin
                    bm[j] = bm[j] ^ s[i];
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            t[i] = bm[i] ^ rotl(bm[i], ROT_A[i]) ^ rotl(bm[i], ROT_B[i]) ^ rc[i*32 +: 32];
        end
        for (int i = 0; i < 16; i += 2) begin
            lo       = rotl(t[i] + t[i+1], 8);
            hi       = rotl(t[i+1], 24) + lo;
            t[i]     = lo;
            t[i+1]   = hi;
        end
        return t;
    endfunction

    // Sub-rounds past the last round pass the state through, covering a partial final cycle.
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_active
        assign sub_active[gi] = (round_reg + 7'(gi)) < NUM_ROUNDS_W;
    end

    always_comb begin
        round_out = work_reg;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            if (sub_active[k]) begin
                round_out = es_round(round_out, rc_consts[k*512 +: 512]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            out_reg       <= '0;
            round_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            out_reg       <= out_next;
            round_reg     <= round_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        out_next       = out_reg;
        round_next     = round_reg;
        out_valid_next = out_valid_reg;
        round_sum      = round_reg + RPC_W;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = state_input;
                    round_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                work_next  = round_out;
                round_next = round_sum;
                if (round_sum >= NUM_ROUNDS_W) begin
                    out_next       = round_out;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by rst so in_ready is low for the whole reset interval.
    assign in_ready      = (state_reg == IDLE) && !rst;
    assign out_valid     = out_valid_reg;
    assign state_output  = out_reg;
    assign rc_base_round = (state_reg == RUN) ? round_reg[5:0] : 6'd0;

endmodule

// File: doc/eaglesong_permutation_iter.md
Name: eaglesong_permutation_iter

Overview:
- Complete Eaglesong permutation over a 16 x 32-bit state, iterated NUM_ROUNDS times.
- Each round applies four steps in order: bit-matrix, circulant, constant injection, add-rotate-add.
- Runs ROUNDS_PER_CYCLE rounds per clock (unrolled). Round constants come from an external ROM through a lookup port.
- Valid/ready handshake on both sides. Sits between the absorb/squeeze controller and the sponge state register.

Parameters:
- NUM_ROUNDS, 43, total rounds per permutation (1..63).
- ROUNDS_PER_CYCLE, 1, rounds evaluated combinationally per clock (1..NUM_ROUNDS). Need not divide NUM_ROUNDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input state is presented.
- in_ready  output  1  block can accept a new state.
- state_input  input  [31:0] x [15:0]  state to permute.
- out_valid  output  1  state_output holds the finished result.
- out_ready  input  1  consumer accepts the result.
- state_output  output  [31:0] x [15:0]  permuted state, registered.
- rc_base_round  output  6  index of the first round evaluated this cycle.
- rc_consts  input  ROUNDS_PER_CYCLE*512  injection constants. Slice k is bits [k*512 +: 512] and holds round rc_base_round+k. Word i of a round is bits [i*32 +: 32]. The ROM is combinational and valid the same cycle.

Behaviour:
- Reset values: in_ready=0 during reset, 1 once released; out_valid=0; state_output all zero; rc_base_round=0; FSM in IDLE.
- FSM states:
  - IDLE (in_ready=1): on in_valid, latch state_input into the working register, set round=0, go to RUN.
  - RUN (in_ready=0): each cycle, replace the working state with ROUNDS_PER_CYCLE chained rounds starting at round r=rc_base_round.
    - Any sub-round with index r+k >= NUM_ROUNDS passes its input through unchanged. This handles a partial last cycle.
    - round += ROUNDS_PER_CYCLE. When round reaches or exceeds NUM_ROUNDS, copy the result to state_output, set out_valid=1, go to DONE.
  - DONE (in_ready=0): hold state_output and out_valid stable. On out_ready, clear out_valid and go to IDLE.
- Latency: in_valid accepted at edge N; out_valid=1 after edge N+ceil(NUM_ROUNDS/ROUNDS_PER_CYCLE). Defaults give 43 cycles.
- Throughput: one permutation per latency+2 cycles. There is no skid buffer; back-pressure stalls in DONE indefinitely.
- Round definition, all arithmetic mod 2^32, rotl = rotate left:
  - Bit-matrix: out[j] = XOR over i of (M[16*i+j] ? s[i] : 0), with M = 256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf (bit 0 = LSB).
  - Circulant: s[i] ^= rotl(s[i],a_i) ^ rotl(s[i],b_i). Pairs (a,b) for i=0..15: (2,4) (13,22) (4,19) (3,14) (27,31) (3,8) (17,26) (3,12) (18,22) (12,18) (4,7) (4,31) (12,27) (7,17) (7,8) (1,13).
  - Injection: s[i] ^= rc word i for that round.
  - ARA, for each even i: s[i]+=s[i+1]; s[i]=rotl(s[i],8); s[i+1]=rotl(s[i+1],24); s[i+1]+=s[i].
- rc_base_round equals the round register in RUN and is 0 otherwise.
- in_valid outside IDLE is ignored; state_input is not sampled.
- out_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE aborts immediately. All outputs return to reset values and the in-flight state is discarded.

Test Plan:
- Reset, then all-zero state with rc_consts all zero and defaults -> out_valid rises exactly 43 cycles after acceptance; state_output all 0x00000000.
- NUM_ROUNDS=1, state[0]=0x00000001, others 0, rc zero -> after the bit-matrix step, words {0,1,2,3,5,7,8,9,10,11,15}=1 and the rest 0. Final output matches the golden C model.
- Defaults with the real 43x16 constant ROM and Eaglesong reference test vectors -> bit-exact match to the C model; rc_base_round steps 0..42.
- ROUNDS_PER_CYCLE=5, NUM_ROUNDS=43 -> rc_base_round sequence 0,5,...,40; out_valid after 9 cycles; result identical to the ROUNDS_PER_CYCLE=1 run.
- Hold out_ready=0 for 20 cycles after out_valid -> out_valid and state_output stable, in_ready=0, in_valid ignored. Pulse out_ready -> next cycle out_valid=0, in_ready=1.
- Assert rst at RUN cycle 10 -> out_valid=0 and state_output zero asynchronously. A following new input completes normally with the correct result.
